sample_burst_tx: RTL and testbench
==================================

Name: sample_burst_tx

Overview:
- Transmit-side counterpart of the sample-count block: streams a fixed-length burst of samples toward a downstream consumer over a valid/ready handshake.
- Samples are buffered in a small internal FIFO. Transmitted samples are counted, and burst completion is flagged when the count reaches the burst length.
- Sits between the sample producer (writes FIFO) and the filter datapath, whose own counter tracks samples consumed.

Parameters:
- DATA_W, 16, sample width in bits
- FIFO_DEPTH, 4, FIFO entries; power of 2, >= 2
- CNT_W, 10, width of sent-sample counter
- BURST_LEN, 1000, samples per burst; 1 <= BURST_LEN <= 2^CNT_W - 1

Ports:
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous reset, active-low
- start  in  1  begin a burst (honoured only in IDLE)
- abort  in  1  terminate burst, flush FIFO
- wr_en  in  1  push wr_data into FIFO
- wr_data  in  DATA_W  sample to push
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries
- tx_valid  out  1  tx_data holds a sample for the consumer
- tx_data  out  DATA_W  FIFO head sample
- tx_ready  in  1  consumer accepts the sample
- busy  out  1  state is STREAM
- burst_done  out  1  one-cycle pulse on burst completion
- sent_count  out  CNT_W  samples transferred in the current/last burst

Behaviour:
- Reset (n_rst low, async): state IDLE, FIFO empty, sent_count=0. All outputs 0 (fifo_full=0, tx_valid=0, tx_data=0, busy=0, burst_done=0).
- FIFO push: wr_en && !fifo_full writes wr_data at tail next edge.
  - wr_en while full: write dropped, no state change, even if a pop occurs the same cycle.
  - Pushes are accepted in every state, except in a cycle where abort=1.
- FIFO pop: occurs only on a transfer (tx_valid && tx_ready). Head advances next edge.
- tx_valid = (state==STREAM) && FIFO not empty. tx_data = FIFO head (registered storage, combinational read).
- Once tx_valid is high, tx_data is stable until transfer; the only exception is abort.
- tx_data is 0 when the FIFO is empty.
- Push and pop in the same cycle on a non-full FIFO: occupancy unchanged, both take effect.
- States:
  - IDLE:
    - start=1 -> STREAM; sent_count cleared to 0 at the same edge.
    - FIFO contents are retained; pre-filling before start is allowed.
  - STREAM:
    - Each transfer increments sent_count.
    - When the transfer brings sent_count to BURST_LEN -> DONE.
    - start is ignored in this state.
  - DONE: burst_done=1 for exactly this one cycle, then -> IDLE. sent_count holds BURST_LEN.
- Zero latency from FIFO non-empty in STREAM to tx_valid. The first sample pushed into an empty FIFO in STREAM appears on tx_valid the cycle after the push.
- Transfers stop exactly at BURST_LEN. Surplus FIFO data stays for the next burst, and tx_valid=0 in DONE/IDLE.
- abort=1 (any state, priority over start, wr_en and transfer):
  - next state IDLE, FIFO flushed, sent_count=0, no burst_done pulse;
  - the transfer in the abort cycle does not count;
  - tx_valid may drop without a transfer on abort.
- start and abort in the same cycle: abort wins, stay IDLE.
- sent_count never wraps, since BURST_LEN < 2^CNT_W.

Optional Feature:
- Macro: SAMPLE_BURST_TX_UNDERRUN_CNT_EN
- Defined:
  - adds output underrun_cnt [7:0];
  - increments each cycle with state==STREAM && FIFO empty, saturating at 255;
  - cleared on reset, on start accepted in IDLE, and on abort.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset mid-burst: after 5 transfers of a burst, assert n_rst low asynchronously (mid-cycle) -> all outputs 0 immediately, FIFO empty; after release, tx_valid stays 0 until start.
- Full burst, BURST_LEN=1000, tx_ready=1, producer pushes a ramp 0..999 whenever !fifo_full -> 1000 transfers in order with tx_data 0..999; burst_done pulses once, the cycle after transfer 1000; sent_count=1000; busy then 0.
- Backpressure: pre-fill 4 samples (0xA1..0xA4), start, tx_ready low 3 cycles -> tx_valid=1 with tx_data=0xA1 held stable 3 cycles; fifo_full=1; a push of 0xBB while full is dropped (later sequence 0xA1..0xA4 only).
- Simultaneous push/pop at occupancy 2 -> occupancy stays 2; order preserved; fifo_full stays 0.
- Abort after 500 transfers, FIFO holding 3 samples -> next cycle state IDLE, tx_valid=0, sent_count=0, FIFO empty, no burst_done; a following start runs a clean burst from sent_count 0.
- With SAMPLE_BURST_TX_UNDERRUN_CNT_EN: start with empty FIFO, wait 300 cycles -> underrun_cnt=255 (saturated); after the next start it reads 0.

Source files
------------

// File: rtl/sample_burst_tx.sv
// Burst transmitter: small FIFO feeding a valid/ready consumer; counts transfers up to BURST_LEN.
// Optional underrun counter enabled by defining SAMPLE_BURST_TX_UNDERRUN_CNT_EN.
module sample_burst_tx #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 10,
  parameter int BURST_LEN  = 1000
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              abort,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              fifo_full,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_ready,
  output logic              busy,
  output logic              burst_done,
  output logic [CNT_W-1:0]  sent_count,
`ifdef SAMPLE_BURST_TX_UNDERRUN_CNT_EN
  output logic [7:0]        underrun_cnt,
`endif
  output logic [1:0]        state_dbg
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_STREAM = 2'd1, S_DONE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0]  mem_d [FIFO_DEPTH];
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]      occ;
  logic               fifo_empty, full, push, pop;

  // Handshake: a sample transfers on a rising edge where tx_valid && tx_ready;
  // once raised, tx_valid/tx_data hold until that transfer (abort excepted).
  assign occ        = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (occ == '0);
  assign full       = (occ == PW'(FIFO_DEPTH));
  assign push       = wr_en && !full && !abort;
  assign pop        = tx_valid && tx_ready && !abort;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (start) state_d = S_STREAM;
        S_STREAM: if (pop && (cnt_q == CNT_W'(BURST_LEN - 1))) state_d = S_DONE;
        S_DONE:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (state_q == S_STREAM);
    burst_done = (state_q == S_DONE);
    tx_valid   = (state_q == S_STREAM) && !fifo_empty;
    tx_data    = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    fifo_full  = full;
    sent_count = cnt_q;
    state_dbg  = state_q;
  end

  // Abort flushes by resetting both pointers; stale storage is never read.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < FIFO_DEPTH; i++) mem_d[i] = mem_q[i];
    if (abort) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q[AW-1:0]] = wr_data;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      if ((state_q == S_IDLE) && start) cnt_d = '0;
      else if (pop)                     cnt_d = cnt_q + 1'b1;
    end
  end

`ifdef SAMPLE_BURST_TX_UNDERRUN_CNT_EN
  logic [7:0] urun_q, urun_d;

  always_comb begin
    urun_d = urun_q;
    if (abort || ((state_q == S_IDLE) && start)) urun_d = '0;
    else if ((state_q == S_STREAM) && fifo_empty && (urun_q != 8'hFF)) urun_d = urun_q + 8'd1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) urun_q <= '0;
    else        urun_q <= urun_d;
  end

  assign underrun_cnt = urun_q;
`endif

endmodule

// File: tb/tb_sample_burst_tx.sv
// Directed bench for sample_burst_tx: FIFO model queue checks every transfer, plus hand-computed spot checks.
module tb_sample_burst_tx;
  localparam int DATA_W     = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 10;
  localparam int BURST_LEN  = 1000;

  logic              clk, n_rst, start, abort, wr_en, tx_ready;
  logic [DATA_W-1:0] wr_data, tx_data;
  logic              fifo_full, tx_valid, busy, burst_done;
  logic [CNT_W-1:0]  sent_count;
  logic [1:0]        state_dbg;
`ifdef SAMPLE_BURST_TX_UNDERRUN_CNT_EN
  logic [7:0]        underrun_cnt;
`endif

  sample_burst_tx #(
    .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W), .BURST_LEN(BURST_LEN)
  ) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
    .wr_en(wr_en), .wr_data(wr_data), .fifo_full(fifo_full),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .busy(busy), .burst_done(burst_done), .sent_count(sent_count),
`ifdef SAMPLE_BURST_TX_UNDERRUN_CNT_EN
    .underrun_cnt(underrun_cnt),
`endif
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_xfer = 0;
  int n_pulse = 0;
  logic [DATA_W-1:0] ramp;
  logic [DATA_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: score the transfer/push about to happen, then advance to the next falling edge.
  task automatic tick_mon();
    logic push_ok, pop_ok;
    push_ok = wr_en && (exp_q.size() < FIFO_DEPTH) && !abort;
    pop_ok  = tx_valid && tx_ready && !abort;
    if (pop_ok) begin
      check("xfer_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("xfer_data", tx_data, exp_q.pop_front());
      n_xfer++;
    end
    if (abort) exp_q.delete();
    else if (push_ok) exp_q.push_back(wr_data);
    @(posedge clk);
    @(negedge clk);
    if (burst_done) n_pulse++;
  endtask

  task automatic push1(input logic [DATA_W-1:0] d);
    wr_en = 1'b1; wr_data = d;
    tick_mon();
    wr_en = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick_mon();
    start = 1'b0;
    n_xfer = 0;
  endtask

  task automatic drain(input int max_cyc);
    tx_ready = 1'b1;
    for (int c = 0; c < max_cyc && exp_q.size() != 0; c++) tick_mon();
    check("drain_done", (exp_q.size() == 0), 1);
  endtask

  task automatic feed(input int target, input logic [DATA_W-1:0] ramp_end, input int max_cyc);
    logic acc;
    tx_ready = 1'b1;
    for (int c = 0; c < max_cyc && n_xfer < target; c++) begin
      wr_en   = (ramp < ramp_end);
      wr_data = ramp;
      acc = wr_en && (exp_q.size() < FIFO_DEPTH) && !abort;
      tick_mon();
      if (acc) ramp++;
    end
    wr_en = 1'b0;
    check("feed_count", n_xfer, target);
  endtask

  initial begin
    n_rst = 1'b0; start = 1'b0; abort = 1'b0; wr_en = 1'b0; wr_data = '0; tx_ready = 1'b0;
    ramp = '0;
    #2;
    check("rst_fifo_full", fifo_full, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_burst_done", burst_done, 0);
    check("rst_sent_count", sent_count, 0);
    @(negedge clk);
    n_rst = 1'b1;
    tick_mon();

    // Backpressure with a prefilled FIFO and a dropped push while full
    push1(16'hA1); push1(16'hA2); push1(16'hA3); push1(16'hA4);
    check("pre_full", fifo_full, 1);
    check("pre_idle_valid", tx_valid, 0);
    check("pre_head", tx_data, 16'hA1);
    tx_ready = 1'b0;
    do_start();
    check("bp_busy", busy, 1);
    check("bp_valid", tx_valid, 1);
    check("bp_data0", tx_data, 16'hA1);
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin wr_en = 1'b1; wr_data = 16'hBB; end
      tick_mon();
      wr_en = 1'b0;
      check("bp_hold_valid", tx_valid, 1);
      check("bp_hold_data", tx_data, 16'hA1);
      check("bp_hold_full", fifo_full, 1);
    end
    drain(10);
    check("bp_xfers", n_xfer, 4);
    check("bp_sent", sent_count, 4);
    check("bp_empty_valid", tx_valid, 0);
    check("bp_empty_data", tx_data, 0);

    // Simultaneous push/pop at occupancy 2; start ignored while streaming
    tx_ready = 1'b0;
    push1(16'hC1); push1(16'hC2);
    check("pp_valid", tx_valid, 1);
    check("pp_head", tx_data, 16'hC1);
    tx_ready = 1'b1; wr_en = 1'b1; wr_data = 16'hC3; start = 1'b1;
    tick_mon();
    tx_ready = 1'b0; wr_en = 1'b0; start = 1'b0;
    check("pp_full", fifo_full, 0);
    check("pp_head2", tx_data, 16'hC2);
    check("pp_sent", sent_count, 5);
    push1(16'hC4);
    check("pp_occ3", fifo_full, 0);
    push1(16'hC5);
    check("pp_occ4", fifo_full, 1);
    drain(10);
    check("pp_sent_end", sent_count, 9);
    check("pp_busy", busy, 1);

    // Abort at 500 transfers with 3 samples buffered
    ramp = 16'h0100;
    feed(500, 16'hFFFF, 2000);
    check("ab_sent500", sent_count, 500);
    tx_ready = 1'b0;
    for (int c = 0; c < 8 && exp_q.size() < 3; c++) begin
      push1(ramp);
      ramp++;
    end
    check("ab_occ3", exp_q.size(), 3);
    abort = 1'b1; tx_ready = 1'b1; wr_en = 1'b1; wr_data = 16'hEE;
    tick_mon();
    abort = 1'b0; wr_en = 1'b0;
    n_xfer = 0;
    check("ab_state", state_dbg, 0);
    check("ab_valid", tx_valid, 0);
    check("ab_sent", sent_count, 0);
    check("ab_full", fifo_full, 0);
    check("ab_data_empty", tx_data, 0);
    check("ab_no_done", burst_done, 0);
    tick_mon();
    check("ab_idle_valid", tx_valid, 0);
    check("ab_pulses", n_pulse, 0);

    // Full burst of 1000 ramp samples
    ramp = '0;
    do_start();
    check("fb_start_sent", sent_count, 0);
    check("fb_busy", busy, 1);
    feed(BURST_LEN, 16'd1000, 3000);
    check("fb_done", burst_done, 1);
    check("fb_state_done", state_dbg, 2);
    check("fb_sent", sent_count, 1000);
    check("fb_busy_done", busy, 0);
    check("fb_valid_done", tx_valid, 0);
    tick_mon();
    check("fb_done_clr", burst_done, 0);
    check("fb_idle", state_dbg, 0);
    check("fb_sent_hold", sent_count, 1000);
    check("fb_pulses", n_pulse, 1);

    // Asynchronous reset in the middle of a burst
    ramp = 16'h0500;
    do_start();
    feed(5, 16'hFFFF, 50);
    @(posedge clk);
    #2 n_rst = 1'b0;
    #1;
    exp_q.delete();
    check("mr_fifo_full", fifo_full, 0);
    check("mr_valid", tx_valid, 0);
    check("mr_data", tx_data, 0);
    check("mr_busy", busy, 0);
    check("mr_done", burst_done, 0);
    check("mr_sent", sent_count, 0);
    @(negedge clk);
    n_rst = 1'b1;
    tx_ready = 1'b1;
    push1(16'h0077);
    tick_mon(); tick_mon();
    check("mr_post_valid", tx_valid, 0);
    check("mr_post_state", state_dbg, 0);
    check("mr_post_head", tx_data, 16'h0077);

`ifdef SAMPLE_BURST_TX_UNDERRUN_CNT_EN
    abort = 1'b1; tick_mon(); abort = 1'b0;
    do_start();
    check("ur_start0", underrun_cnt, 0);
    for (int c = 0; c < 300; c++) tick_mon();
    check("ur_sat", underrun_cnt, 255);
    abort = 1'b1; tick_mon(); abort = 1'b0;
    check("ur_abort", underrun_cnt, 0);
    do_start();
    check("ur_restart", underrun_cnt, 0);
`endif

    check("final_pulses", n_pulse, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
